// File: rtl/sram_pkg.sv
// Shared types for the asynchronous SRAM controller:
// FSM states, command op encoding and pin strobe patterns.
package sram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ACCESS,
        ST_WR_SETUP,
        ST_WR_PULSE,
        ST_WR_HOLD,
        ST_TURN
    } sram_state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } sram_op_e;

    typedef struct packed {
        logic ce_n;
        logic oe_n;
        logic we_n;
        logic dq_oe;
    } sram_strb_t;

    localparam sram_strb_t STRB_OFF      = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, dq_oe: 1'b0};
    localparam sram_strb_t STRB_RD       = '{ce_n: 1'b0, oe_n: 1'b0, we_n: 1'b1, dq_oe: 1'b0};
    localparam sram_strb_t STRB_WR_DRV   = '{ce_n: 1'b0, oe_n: 1'b1, we_n: 1'b1, dq_oe: 1'b1};
    localparam sram_strb_t STRB_WR_PULSE = '{ce_n: 1'b0, oe_n: 1'b1, we_n: 1'b0, dq_oe: 1'b1};

    function automatic sram_strb_t strb_of(sram_state_e s);
        sram_strb_t r;
        case (s)
            ST_RD_ACCESS: r = STRB_RD;
            ST_WR_SETUP:  r = STRB_WR_DRV;
            ST_WR_PULSE:  r = STRB_WR_PULSE;
            ST_WR_HOLD:   r = STRB_WR_DRV;
            default:      r = STRB_OFF;
        endcase
        return r;
    endfunction

    function automatic int max_of(int a, int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sram_phase_timer.sv
// Phase counter for the SRAM FSM: restarts on state entry,
// saturates, and flags the last cycle of the current phase.
module sram_phase_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] last_idx,
    output logic             last
);

    logic [CNT_W-1:0] cnt;

    // Count cycles spent in the current phase; hold at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign last = (cnt == last_idx);

endmodule

// File: rtl/sram_async_ctrl.sv
// Asynchronous SRAM controller: single-beat valid/ready commands,
// programmable phase timing, registered strobes and split data pins.
module sram_async_ctrl
    import sram_pkg::*;
#(
    parameter  int ADDR_W  = 18,
    parameter  int DATA_W  = 16,
    parameter  int T_RD    = 12,
    parameter  int T_SETUP = 1,
    parameter  int T_WP    = 6,
    parameter  int T_HOLD  = 1,
    parameter  int T_TURN  = 1,
    localparam int BE_W    = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [BE_W-1:0]   cmd_be,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              wr_done,
    output logic              busy,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [BE_W-1:0]   sram_bw_n,
    input  logic [DATA_W-1:0] dq_in,
    output logic [DATA_W-1:0] dq_out,
    output logic              dq_oe
);

    localparam int T_MAX = max_of(max_of(max_of(T_RD, T_SETUP), max_of(T_WP, T_HOLD)), T_TURN);
    localparam int CNT_W = $clog2(T_MAX + 1);

    sram_state_e      state;
    sram_state_e      state_n;
    sram_op_e         op_q;
    logic [BE_W-1:0]  be_q;
    logic [BE_W-1:0]  be_nx;
    logic [CNT_W-1:0] last_idx;
    logic             last;
    logic             accept;
    logic             load;

    assign cmd_ready = !rst && ((state == ST_IDLE) ||
                                (state == ST_RD_ACCESS && last) ||
                                (state == ST_WR_HOLD && last));
    assign accept    = cmd_valid && cmd_ready;
    assign load      = accept || (last && state != ST_IDLE);
    assign be_nx     = accept ? cmd_be : be_q;
    assign busy      = (state != ST_IDLE);

    sram_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .last_idx (last_idx),
        .last     (last)
    );

    // Length of the phase the FSM currently sits in
    always_comb begin
        last_idx = '0;
        unique case (state)
            ST_RD_ACCESS: last_idx = CNT_W'(T_RD - 1);
            ST_WR_SETUP:  last_idx = CNT_W'(T_SETUP - 1);
            ST_WR_PULSE:  last_idx = CNT_W'(T_WP - 1);
            ST_WR_HOLD:   last_idx = CNT_W'(T_HOLD - 1);
            ST_TURN:      last_idx = CNT_W'(T_TURN - 1);
            default:      last_idx = '0;
        endcase
    end

    // Next state; a new command may chain on the last read/hold cycle
    always_comb begin
        state_n = state;
        unique case (state)
            ST_IDLE: begin
                if (accept) state_n = cmd_we ? ST_WR_SETUP : ST_RD_ACCESS;
            end
            ST_RD_ACCESS: begin
                if (last) begin
                    if (!accept)     state_n = ST_IDLE;
                    else if (cmd_we) state_n = ST_TURN;
                    else             state_n = ST_RD_ACCESS;
                end
            end
            ST_WR_SETUP: begin
                if (last) state_n = ST_WR_PULSE;
            end
            ST_WR_PULSE: begin
                if (last) state_n = ST_WR_HOLD;
            end
            ST_WR_HOLD: begin
                if (last) begin
                    if (!accept)     state_n = ST_IDLE;
                    else if (cmd_we) state_n = ST_WR_SETUP;
                    else             state_n = ST_TURN;
                end
            end
            ST_TURN: begin
                if (last) state_n = (op_q == OP_WR) ? ST_WR_SETUP : ST_RD_ACCESS;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State, command latch and glitch-free pin registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            op_q      <= OP_RD;
            be_q      <= '0;
            sram_addr <= '0;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            dq_oe     <= 1'b0;
            sram_bw_n <= '1;
            dq_out    <= '0;
            rsp_rdata <= '0;
            rsp_valid <= 1'b0;
            wr_done   <= 1'b0;
        end else begin
            state <= state_n;
            {sram_ce_n, sram_oe_n, sram_we_n, dq_oe} <= strb_of(state_n);
            sram_bw_n <= (state_n inside {ST_IDLE, ST_TURN}) ? '1 : ~be_nx;
            rsp_valid <= (state == ST_RD_ACCESS) && last;
            wr_done   <= (state == ST_WR_HOLD) && last;
            if (state == ST_RD_ACCESS && last) rsp_rdata <= dq_in;
            if (accept) begin
                op_q      <= sram_op_e'(cmd_we);
                be_q      <= cmd_be;
                sram_addr <= cmd_addr;
                if (cmd_we) dq_out <= cmd_wdata;
            end
        end
    end

endmodule
